// File: rtl/memory_pipe_arbiter_n.sv
// N-channel memory pipe arbiter: arbitrates core-side channel commands onto a
// single memory command port, records each issued command (channel, rw) in an
// in-order tag FIFO, and routes returning read data / store acks back to the
// channel that issued the matching command.
module memory_pipe_arbiter_n #(
    parameter int unsigned P_CH    = 2,
    parameter int unsigned P_DEPTH = 4,
    parameter int unsigned P_MODE  = 0
) (
    input  logic                         iCLOCK,
    input  logic                         iRESET_SYNC,
    input  logic [P_CH-1:0]              iCH_REQ,
    output logic [P_CH-1:0]              oCH_LOCK,
    input  logic [2*P_CH-1:0]            iCH_ORDER,
    input  logic [P_CH-1:0]              iCH_RW,
    input  logic [32*P_CH-1:0]           iCH_ADDR,
    input  logic [32*P_CH-1:0]           iCH_DATA,
    output logic [P_CH-1:0]              oCH_VALID,
    input  logic [P_CH-1:0]              iCH_BUSY,
    output logic [64*P_CH-1:0]           oCH_DATA,
    output logic                         oMEMORY_REQ,
    input  logic                         iMEMORY_LOCK,
    output logic [1:0]                   oMEMORY_ORDER,
    output logic                         oMEMORY_RW,
    output logic [31:0]                  oMEMORY_ADDR,
    output logic [31:0]                  oMEMORY_DATA,
    input  logic                         iMEMORY_VALID,
    input  logic                         iMEMORY_STORE_ACK,
    output logic                         oMEMORY_BUSY,
    input  logic [63:0]                  iMEMORY_DATA,
    output logic [$clog2(P_DEPTH+1)-1:0] oOUTSTANDING,
    output logic                         oERROR
);

    localparam int unsigned CH_W  = (P_CH > 1) ? $clog2(P_CH) : 1;
    localparam int unsigned DP_W  = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(P_DEPTH+1);

    // Per-channel views of the flattened input buses
    logic [1:0]  ch_order [P_CH];
    logic [31:0] ch_addr  [P_CH];
    logic [31:0] ch_data  [P_CH];

    // Arbitration
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] rr_idx;
    logic            grant_valid;
    logic            cmd_free;
    logic            can_accept;
    logic            push;

    // Command register
    logic        cmd_v_q, cmd_v_d;
    logic [1:0]  cmd_order_q, cmd_order_d;
    logic        cmd_rw_q, cmd_rw_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_data_q, cmd_data_d;

    // Tag FIFO
    logic [CH_W-1:0]  tag_ch_q [P_DEPTH];
    logic             tag_rw_q [P_DEPTH];
    logic [DP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    // Response register
    logic            resp_v_q, resp_v_d;
    logic [CH_W-1:0] resp_dest_q, resp_dest_d;
    logic [63:0]     resp_data_q, resp_data_d;
    logic            mem_busy;
    logic            rsp_take;
    logic            err_q, err_d;

    // Unpack flattened channel buses
    always_comb begin
        for (int unsigned i = 0; i < P_CH; i++) begin
            ch_order[i] = iCH_ORDER[2*i +: 2];
            ch_addr[i]  = iCH_ADDR[32*i +: 32];
            ch_data[i]  = iCH_DATA[32*i +: 32];
        end
    end

    // Grant selection: round-robin from ptr+1, or fixed lowest-index priority
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        rr_idx      = '0;
        if (P_MODE == 1) begin
            for (int unsigned k = 0; k < P_CH; k++) begin
                if (!grant_valid && iCH_REQ[CH_W'(k)]) begin
                    grant_valid = 1'b1;
                    grant       = CH_W'(k);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= P_CH; k++) begin
                rr_idx = CH_W'((32'(ptr_q) + k) % P_CH);
                if (!grant_valid && iCH_REQ[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant       = rr_idx;
                end
            end
        end
    end

    assign cmd_free   = !cmd_v_q || !iMEMORY_LOCK;
    assign can_accept = cmd_free && (count_q < CNT_W'(P_DEPTH));
    assign push       = grant_valid && can_accept && !iRESET_SYNC;

    // Per-channel lock; forced high while reset is held
    always_comb begin
        for (int unsigned i = 0; i < P_CH; i++) begin
            oCH_LOCK[i] = iRESET_SYNC || !can_accept || (grant_valid && (grant != CH_W'(i)));
        end
    end

    // Command register and round-robin pointer next state
    always_comb begin
        cmd_v_d     = cmd_v_q;
        cmd_order_d = cmd_order_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        ptr_d       = ptr_q;
        if (push) begin
            cmd_v_d     = 1'b1;
            cmd_order_d = ch_order[grant];
            cmd_rw_d    = iCH_RW[grant];
            cmd_addr_d  = ch_addr[grant];
            cmd_data_d  = ch_data[grant];
            if (P_MODE == 0) begin
                ptr_d = grant;
            end
        end else if (cmd_v_q && !iMEMORY_LOCK) begin
            cmd_v_d = 1'b0;
        end
    end

    assign mem_busy = resp_v_q && iCH_BUSY[resp_dest_q];
    assign rsp_take = (iMEMORY_VALID || iMEMORY_STORE_ACK) && !mem_busy;
    assign pop      = rsp_take && (count_q != '0);

    // FIFO pointers, occupancy, response register and sticky error next state
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        resp_v_d    = resp_v_q;
        resp_dest_d = resp_dest_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (pop) begin
            resp_v_d    = 1'b1;
            resp_dest_d = tag_ch_q[rd_ptr_q];
            resp_data_d = iMEMORY_VALID ? iMEMORY_DATA : '0;
        end else if (resp_v_q && !iCH_BUSY[resp_dest_q]) begin
            resp_v_d = 1'b0;
        end
        if ((rsp_take && (count_q == '0)) ||
            (iMEMORY_VALID && iMEMORY_STORE_ACK) ||
            (pop && (tag_rw_q[rd_ptr_q] ? !iMEMORY_STORE_ACK : iMEMORY_STORE_ACK))) begin
            err_d = 1'b1;
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ptr_q       <= CH_W'(P_CH - 1);
            cmd_v_q     <= 1'b0;
            cmd_order_q <= '0;
            cmd_rw_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            resp_v_q    <= 1'b0;
            resp_dest_q <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cmd_v_q     <= cmd_v_d;
            cmd_order_q <= cmd_order_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            resp_v_q    <= resp_v_d;
            resp_dest_q <= resp_dest_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    // Tag storage; contents are only meaningful below the occupancy count
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            tag_ch_q[wr_ptr_q] <= grant;
            tag_rw_q[wr_ptr_q] <= iCH_RW[grant];
        end
    end

    // Response fan-out: every channel sees the same data, valid only at dest
    always_comb begin
        for (int unsigned i = 0; i < P_CH; i++) begin
            oCH_VALID[i]         = resp_v_q && (resp_dest_q == CH_W'(i));
            oCH_DATA[64*i +: 64] = resp_data_q;
        end
    end

    assign oMEMORY_REQ   = cmd_v_q;
    assign oMEMORY_ORDER = cmd_order_q;
    assign oMEMORY_RW    = cmd_rw_q;
    assign oMEMORY_ADDR  = cmd_addr_q;
    assign oMEMORY_DATA  = cmd_data_q;
    assign oMEMORY_BUSY  = mem_busy;
    assign oOUTSTANDING  = count_q;
    assign oERROR        = err_q;

endmodule

// File: tb/tb_memory_pipe_arbiter_n.sv
// Directed bench: one round-robin instance exercises issue, FIFO full,
// response routing, back-pressure, errors and reset; a fixed-priority
// instance checks channel 0 dominance.
module tb_memory_pipe_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Round-robin instance signals
    logic [1:0]   req = '0, lock, rw = '0, busy = '0, chv;
    logic [3:0]   order = '0;
    logic [63:0]  addr = '0, wdata = '0;
    logic [127:0] chd;
    logic         mreq, mrw, mbusy, merr;
    logic         mlock = 1'b0, mvalid = 1'b0, mack = 1'b0;
    logic [1:0]   morder;
    logic [31:0]  maddr, mdata;
    logic [63:0]  rdata = '0;
    logic [2:0]   outst;

    // Fixed-priority instance signals
    logic [1:0]   p_req = '0, p_lock, p_chv;
    logic [63:0]  p_addr = {32'h0000_0020, 32'h0000_0010};
    logic [127:0] p_chd;
    logic         p_mreq, p_mrw, p_mbusy, p_merr;
    logic [1:0]   p_morder;
    logic [31:0]  p_maddr, p_mdata;
    logic [2:0]   p_outst;

    memory_pipe_arbiter_n #(.P_CH(2), .P_DEPTH(4), .P_MODE(0)) u_rr (
        .iCLOCK(clk), .iRESET_SYNC(rst),
        .iCH_REQ(req), .oCH_LOCK(lock), .iCH_ORDER(order), .iCH_RW(rw),
        .iCH_ADDR(addr), .iCH_DATA(wdata), .oCH_VALID(chv), .iCH_BUSY(busy),
        .oCH_DATA(chd), .oMEMORY_REQ(mreq), .iMEMORY_LOCK(mlock),
        .oMEMORY_ORDER(morder), .oMEMORY_RW(mrw), .oMEMORY_ADDR(maddr),
        .oMEMORY_DATA(mdata), .iMEMORY_VALID(mvalid), .iMEMORY_STORE_ACK(mack),
        .oMEMORY_BUSY(mbusy), .iMEMORY_DATA(rdata), .oOUTSTANDING(outst),
        .oERROR(merr)
    );

    memory_pipe_arbiter_n #(.P_CH(2), .P_DEPTH(4), .P_MODE(1)) u_pri (
        .iCLOCK(clk), .iRESET_SYNC(rst),
        .iCH_REQ(p_req), .oCH_LOCK(p_lock), .iCH_ORDER(4'b0), .iCH_RW(2'b0),
        .iCH_ADDR(p_addr), .iCH_DATA(64'h0), .oCH_VALID(p_chv), .iCH_BUSY(2'b0),
        .oCH_DATA(p_chd), .oMEMORY_REQ(p_mreq), .iMEMORY_LOCK(1'b0),
        .oMEMORY_ORDER(p_morder), .oMEMORY_RW(p_mrw), .oMEMORY_ADDR(p_maddr),
        .oMEMORY_DATA(p_mdata), .iMEMORY_VALID(1'b0), .iMEMORY_STORE_ACK(1'b0),
        .oMEMORY_BUSY(p_mbusy), .iMEMORY_DATA(64'h0), .oOUTSTANDING(p_outst),
        .oERROR(p_merr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        #1;
        chk("lock_in_reset", 64'(lock), 64'h3);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req", 64'(mreq), 64'h0);
        chk("rst_outst", 64'(outst), 64'h0);
        chk("rst_valid", 64'(chv), 64'h0);
        chk("rst_err", 64'(merr), 64'h0);
        chk("rst_mbusy", 64'(mbusy), 64'h0);
        chk("rst_lock", 64'(lock), 64'h0);

        // Fixed priority: channel 0 wins every cycle
        p_req = 2'b11;
        #1;
        chk("pri_lock0", 64'(p_lock), 64'h2);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("pri_addr", 64'(p_maddr), 64'h10);
            chk("pri_lock", 64'(p_lock), 64'h2);
        end
        p_req = 2'b00;

        // Round robin: both channels held, alternate grants until FIFO full
        addr = {32'h0000_0200, 32'h0000_0100};
        req  = 2'b11;
        #1;
        chk("rr_lock_first", 64'(lock), 64'h2);
        tick();
        chk("rr_addr1", 64'(maddr), 64'h100);
        chk("rr_req1", 64'(mreq), 64'h1);
        chk("rr_lock1", 64'(lock), 64'h1);
        tick();
        chk("rr_addr2", 64'(maddr), 64'h200);
        chk("rr_lock2", 64'(lock), 64'h2);
        tick();
        chk("rr_addr3", 64'(maddr), 64'h100);
        tick();
        chk("rr_addr4", 64'(maddr), 64'h200);
        chk("full_outst", 64'(outst), 64'h4);
        chk("full_lock", 64'(lock), 64'h3);
        req = 2'b00;
        tick();
        chk("cmd_clear", 64'(mreq), 64'h0);

        // Response while full: no bypass, lock releases next cycle
        mvalid = 1'b1;
        rdata  = 64'hA;
        #1;
        chk("full_nobypass", 64'(lock), 64'h3);
        tick();
        chk("resp1_outst", 64'(outst), 64'h3);
        chk("resp1_valid", 64'(chv), 64'h1);
        chk("resp1_data", chd[63:0], 64'hA);
        chk("resp1_lock", 64'(lock), 64'h0);
        rdata = 64'hB;
        tick();
        chk("resp2_valid", 64'(chv), 64'h2);
        chk("resp2_data", chd[127:64], 64'hB);
        chk("resp2_outst", 64'(outst), 64'h2);
        mvalid = 1'b0;
        tick();
        chk("resp_idle", 64'(chv), 64'h0);

        // Channel back-pressure
        busy   = 2'b01;
        mvalid = 1'b1;
        rdata  = 64'hC;
        tick();
        chk("bp_valid", 64'(chv), 64'h1);
        chk("bp_data", chd[63:0], 64'hC);
        rdata = 64'hD;
        #1;
        chk("bp_mbusy", 64'(mbusy), 64'h1);
        tick();
        chk("bp_hold_valid", 64'(chv), 64'h1);
        chk("bp_hold_data", chd[63:0], 64'hC);
        chk("bp_hold_outst", 64'(outst), 64'h1);
        busy = 2'b00;
        #1;
        chk("bp_release", 64'(mbusy), 64'h0);
        tick();
        chk("bp_next_valid", 64'(chv), 64'h2);
        chk("bp_next_data", chd[127:64], 64'hD);
        chk("bp_next_outst", 64'(outst), 64'h0);
        mvalid = 1'b0;
        tick();
        chk("bp_idle", 64'(chv), 64'h0);

        // ch0 read, ch1 write; read data then store ack
        addr  = {32'h0000_0400, 32'h0000_0300};
        wdata = {32'h0000_DEAD, 32'h0};
        rw    = 2'b10;
        order = 4'b1000;
        req   = 2'b01;
        tick();
        chk("rd_addr", 64'(maddr), 64'h300);
        chk("rd_rw", 64'(mrw), 64'h0);
        req = 2'b10;
        tick();
        chk("wr_addr", 64'(maddr), 64'h400);
        chk("wr_rw", 64'(mrw), 64'h1);
        chk("wr_data", 64'(mdata), 64'hDEAD);
        chk("wr_order", 64'(morder), 64'h2);
        req    = 2'b00;
        mvalid = 1'b1;
        rdata  = 64'h1234;
        tick();
        chk("rdret_valid", 64'(chv), 64'h1);
        chk("rdret_data", chd[63:0], 64'h1234);
        mvalid = 1'b0;
        mack   = 1'b1;
        tick();
        chk("ack_valid", 64'(chv), 64'h2);
        chk("ack_data", chd[127:64], 64'h0);
        chk("ack_err", 64'(merr), 64'h0);
        mack = 1'b0;
        tick();

        // Response with empty FIFO
        mvalid = 1'b1;
        tick();
        chk("empty_valid", 64'(chv), 64'h0);
        chk("empty_err", 64'(merr), 64'h1);
        mvalid = 1'b0;
        tick();
        chk("err_sticky", 64'(merr), 64'h1);

        // Reset with three outstanding
        req = 2'b01;
        tick();
        tick();
        tick();
        req = 2'b00;
        chk("pre_rst_outst", 64'(outst), 64'h3);
        rst = 1'b1;
        #1;
        chk("rst_lock_mid", 64'(lock), 64'h3);
        tick();
        chk("rst_outst_mid", 64'(outst), 64'h0);
        chk("rst_err_mid", 64'(merr), 64'h0);
        chk("rst_req_mid", 64'(mreq), 64'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_lock", 64'(lock), 64'h0);
        tick();
        chk("post_rst_valid", 64'(chv), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
